// File: rtl/cache_assoc.sv
// cache_assoc: parametrised set-associative, write-back, write-allocate cache
// with one outstanding request, per-set round-robin replacement and an
// explicit ready signal towards the requester.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_req_op/addr/data        requester request (op 0/3 INVALID, 1 READ, 2 WRITE)
//   rx_req_rdy                 high while the cache can accept a request
//   rx_rsp_vld/rx_rsp_data     one-cycle read response strobe and data
//   tx_req_op/addr/data        memory request pulse (same op encoding)
//   tx_rsp_vld/tx_rsp_data     memory read response strobe and data
//   hit_count/miss_count       saturating 16-bit statistics counters
//
// Optional feature: define CACHE_ASSOC_STATS_EN to build the hit/miss
// counters; when undefined both counter ports are tied to zero.
module cache_assoc #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int WAYS        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            rx_req_op,
    input  logic [ADDR_WIDTH-1:0] rx_req_addr,
    input  logic [DATA_WIDTH-1:0] rx_req_data,
    output logic                  rx_req_rdy,
    output logic                  rx_rsp_vld,
    output logic [DATA_WIDTH-1:0] rx_rsp_data,
    output logic [1:0]            tx_req_op,
    output logic [ADDR_WIDTH-1:0] tx_req_addr,
    output logic [DATA_WIDTH-1:0] tx_req_data,
    input  logic                  tx_rsp_vld,
    input  logic [DATA_WIDTH-1:0] tx_rsp_data,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int          TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int          SETS      = 1 << INDEX_WIDTH;
    localparam int          WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned NWAYS     = WAYS;
    localparam int unsigned NSETS     = SETS;

    localparam logic [1:0] OP_INVALID = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;

    typedef enum logic [1:0] {
        LINE_INVALID = 2'd0,
        LINE_CLEAN   = 2'd1,
        LINE_DIRTY   = 2'd2
    } line_status_t;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t                  state;
    line_status_t            status [WAYS][SETS];
    logic [TAG_WIDTH-1:0]    tags   [WAYS][SETS];
    logic [DATA_WIDTH-1:0]   lines  [WAYS][SETS];
    logic [WAY_BITS-1:0]     rr_ptr [SETS];

    logic [1:0]              cur_op;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [WAY_BITS-1:0]     victim_q;

    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  cur_idx;
    logic [TAG_WIDTH-1:0]    cur_tag;
    logic                    accept;
    logic                    hit;
    logic [WAY_BITS-1:0]     hit_way;
    logic [WAY_BITS-1:0]     victim;
    logic                    found_inv;

    assign req_idx    = rx_req_addr[INDEX_WIDTH-1:0];
    assign req_tag    = rx_req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign cur_idx    = cur_addr[INDEX_WIDTH-1:0];
    assign cur_tag    = cur_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign rx_req_rdy = (state == READY);
    assign accept     = rx_req_rdy && (rx_req_op == OP_READ || rx_req_op == OP_WRITE);

    // Tag lookup and victim choice: first invalid way wins, otherwise the
    // set's round-robin pointer.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = rr_ptr[req_idx];
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (status[w][req_idx] != LINE_INVALID && tags[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!found_inv && status[w][req_idx] == LINE_INVALID) begin
                found_inv = 1'b1;
                victim    = WAY_BITS'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= READY;
            cur_op      <= OP_INVALID;
            cur_addr    <= '0;
            cur_data    <= '0;
            victim_q    <= '0;
            rx_rsp_vld  <= 1'b0;
            rx_rsp_data <= '0;
            tx_req_op   <= OP_INVALID;
            tx_req_addr <= '0;
            tx_req_data <= '0;
            for (int unsigned s = 0; s < NSETS; s++) begin
                rr_ptr[s] <= '0;
                for (int unsigned w = 0; w < NWAYS; w++) begin
                    status[w][s] <= LINE_INVALID;
                    tags[w][s]   <= '0;
                    lines[w][s]  <= '0;
                end
            end
        end else begin
            rx_rsp_vld <= 1'b0;
            tx_req_op  <= OP_INVALID;
            case (state)
                READY: begin
                    if (accept) begin
                        cur_op   <= rx_req_op;
                        cur_addr <= rx_req_addr;
                        cur_data <= rx_req_data;
                        if (hit) begin
                            if (rx_req_op == OP_READ) begin
                                rx_rsp_vld  <= 1'b1;
                                rx_rsp_data <= lines[hit_way][req_idx];
                            end else begin
                                lines[hit_way][req_idx]  <= rx_req_data;
                                status[hit_way][req_idx] <= LINE_DIRTY;
                            end
                        end else begin
                            victim_q <= victim;
                            if (status[victim][req_idx] == LINE_DIRTY) begin
                                tx_req_op   <= OP_WRITE;
                                tx_req_addr <= {tags[victim][req_idx], req_idx};
                                tx_req_data <= lines[victim][req_idx];
                                state       <= WRITEBACK;
                            end else begin
                                tx_req_op   <= OP_READ;
                                tx_req_addr <= rx_req_addr;
                                state       <= FILL;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    tx_req_op   <= OP_READ;
                    tx_req_addr <= cur_addr;
                    state       <= FILL;
                end
                FILL: begin
                    if (tx_rsp_vld) begin
                        tags[victim_q][cur_idx] <= cur_tag;
                        if (cur_op == OP_READ) begin
                            lines[victim_q][cur_idx]  <= tx_rsp_data;
                            status[victim_q][cur_idx] <= LINE_CLEAN;
                            rx_rsp_vld                <= 1'b1;
                            rx_rsp_data               <= tx_rsp_data;
                        end else begin
                            lines[victim_q][cur_idx]  <= cur_data;
                            status[victim_q][cur_idx] <= LINE_DIRTY;
                        end
                        rr_ptr[cur_idx] <= WAY_BITS'((32'(victim_q) + 32'd1) % NWAYS);
                        state           <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

`ifdef CACHE_ASSOC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed testbench for cache_assoc with a scoreboard of expected rx
// responses and tx memory requests (each tagged with its expected cycle).
module tb_cache_assoc;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rx_req_op;
    logic [5:0]  rx_req_addr;
    logic [7:0]  rx_req_data;
    logic        rx_req_rdy;
    logic        rx_rsp_vld;
    logic [7:0]  rx_rsp_data;
    logic [1:0]  tx_req_op;
    logic [5:0]  tx_req_addr;
    logic [7:0]  tx_req_data;
    logic        tx_rsp_vld;
    logic [7:0]  tx_rsp_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_assoc #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (8),
        .INDEX_WIDTH(3),
        .WAYS       (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_req_op  (rx_req_op),
        .rx_req_addr(rx_req_addr),
        .rx_req_data(rx_req_data),
        .rx_req_rdy (rx_req_rdy),
        .rx_rsp_vld (rx_rsp_vld),
        .rx_rsp_data(rx_rsp_data),
        .tx_req_op  (tx_req_op),
        .tx_req_addr(tx_req_addr),
        .tx_req_data(tx_req_data),
        .tx_rsp_vld (tx_rsp_vld),
        .tx_rsp_data(tx_rsp_data),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rx_exp_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] addr;
        logic [7:0] data;
        logic       chk_data;
        int         cyc;
    } tx_exp_t;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every response / memory op must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_rsp_vld) begin
                chk("rx_expected", 32'(rx_q.size() != 0), 32'd1);
                if (rx_q.size() != 0) begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    chk("rx_data", 32'(rx_rsp_data), 32'(e.data));
                    chk("rx_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (tx_req_op != 2'd0) begin
                chk("tx_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) begin
                    tx_exp_t t;
                    t = tx_q.pop_front();
                    chk("tx_op", 32'(tx_req_op), 32'(t.op));
                    chk("tx_addr", 32'(tx_req_addr), 32'(t.addr));
                    chk("tx_cycle", 32'(cyc), 32'(t.cyc));
                    if (t.chk_data) chk("tx_data", 32'(tx_req_data), 32'(t.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // All driving happens 1 time unit after a rising edge.
    task automatic req(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                       output int acc);
        int n;
        n = 0;
        while (!rx_req_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rdy_wait", 32'(rx_req_rdy), 32'd1);
        rx_req_op   = op;
        rx_req_addr = a;
        rx_req_data = d;
        @(posedge clk);
        #1;
        acc       = cyc;
        rx_req_op = 2'd0;
    endtask

    task automatic mem_rsp(input logic [7:0] d, output int t);
        tx_rsp_vld  = 1'b1;
        tx_rsp_data = d;
        @(posedge clk);
        #1;
        t          = cyc;
        tx_rsp_vld = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] d, input int c);
        rx_exp_t e;
        e.data = d;
        e.cyc  = c;
        rx_q.push_back(e);
    endtask

    task automatic push_tx(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                           input logic cd, input int c);
        tx_exp_t t;
        t.op       = op;
        t.addr     = a;
        t.data     = d;
        t.chk_data = cd;
        t.cyc      = c;
        tx_q.push_back(t);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_rx_drained"}, 32'(rx_q.size()), 32'd0);
        chk({tag, "_tx_drained"}, 32'(tx_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_rdy", 32'(rx_req_rdy), 32'd1);
        chk("rst_rsp_vld", 32'(rx_rsp_vld), 32'd0);
        chk("rst_rsp_data", 32'(rx_rsp_data), 32'd0);
        chk("rst_tx_op", 32'(tx_req_op), 32'd0);
        chk("rst_tx_addr", 32'(tx_req_addr), 32'd0);
        chk("rst_tx_data", 32'(tx_req_data), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_misses", 32'(miss_count), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        int a;
        int t;
        logic [15:0] exp_hits;
        logic [15:0] exp_misses;
        rst_n       = 1'b0;
        rx_req_op   = 2'd0;
        rx_req_addr = '0;
        rx_req_data = '0;
        tx_rsp_vld  = 1'b0;
        tx_rsp_data = '0;
        @(posedge clk);
        #1;

        // Clean read miss then read hit.
        do_reset();
        req(2'd1, 6'h09, 8'h00, a);
        push_tx(2'd1, 6'h09, 8'h00, 1'b0, a);
        chk("fill_not_rdy", 32'(rx_req_rdy), 32'd0);
        idle(2);
        mem_rsp(8'h5A, t);
        push_rx(8'h5A, t);
        idle(2);
        req(2'd1, 6'h09, 8'h00, a);
        push_rx(8'h5A, a);
        idle(2);
        drained("s1");
`ifdef CACHE_ASSOC_STATS_EN
        exp_hits   = 16'd1;
        exp_misses = 16'd1;
`else
        exp_hits   = 16'd0;
        exp_misses = 16'd0;
`endif
        chk("hit_count", 32'(hit_count), 32'(exp_hits));
        chk("miss_count", 32'(miss_count), 32'(exp_misses));

        // Write hit stays ready and updates the line.
        req(2'd2, 6'h09, 8'h33, a);
        chk("wr_hit_rdy", 32'(rx_req_rdy), 32'd1);
        idle(1);
        req(2'd1, 6'h09, 8'h00, a);
        push_rx(8'h33, a);
        idle(2);
        drained("s1b");

        // Two-way fill, dirty eviction by round robin.
        do_reset();
        req(2'd1, 6'h01, 8'h00, a);
        push_tx(2'd1, 6'h01, 8'h00, 1'b0, a);
        idle(1);
        mem_rsp(8'h11, t);
        push_rx(8'h11, t);
        idle(1);
        req(2'd1, 6'h09, 8'h00, a);
        push_tx(2'd1, 6'h09, 8'h00, 1'b0, a);
        idle(1);
        mem_rsp(8'h22, t);
        push_rx(8'h22, t);
        idle(1);
        req(2'd2, 6'h01, 8'hA5, a);
        idle(1);
        req(2'd1, 6'h11, 8'h00, a);
        push_tx(2'd2, 6'h01, 8'hA5, 1'b1, a);
        push_tx(2'd1, 6'h11, 8'h00, 1'b0, a + 1);
        idle(3);
        mem_rsp(8'h44, t);
        push_rx(8'h44, t);
        idle(1);
        req(2'd1, 6'h09, 8'h00, a);
        push_rx(8'h22, a);
        idle(2);
        drained("s2");

        // Write miss allocates dirty; requests while busy are ignored.
        do_reset();
        req(2'd2, 6'h22, 8'h77, a);
        push_tx(2'd1, 6'h22, 8'h00, 1'b0, a);
        rx_req_op   = 2'd2;
        rx_req_addr = 6'h3F;
        rx_req_data = 8'hEE;
        idle(2);
        rx_req_op = 2'd0;
        mem_rsp(8'h10, t);
        idle(1);
        req(2'd1, 6'h22, 8'h00, a);
        push_rx(8'h77, a);
        idle(2);
        drained("s3");

        // Reset during FILL aborts; a late memory response is ignored.
        do_reset();
        req(2'd1, 6'h05, 8'h00, a);
        push_tx(2'd1, 6'h05, 8'h00, 1'b0, a);
        idle(2);
        rst_n = 1'b0;
        #2;
        chk("abort_rdy", 32'(rx_req_rdy), 32'd1);
        chk("abort_rsp_vld", 32'(rx_rsp_vld), 32'd0);
        chk("abort_tx_addr", 32'(tx_req_addr), 32'd0);
        chk("abort_tx_op", 32'(tx_req_op), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        mem_rsp(8'h99, t);
        idle(2);
        chk("late_rsp_rdy", 32'(rx_req_rdy), 32'd1);
        req(2'd1, 6'h05, 8'h00, a);
        push_tx(2'd1, 6'h05, 8'h00, 1'b0, a);
        idle(1);
        mem_rsp(8'h66, t);
        push_rx(8'h66, t);
        idle(2);
        drained("s4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
